// File: rtl/dmem_port_adapter_if.sv
// Bus bundle between the pipeline MEM-stage data port and a variable-latency data memory.
// Handshake: dmem_read/dmem_write are levels held by the pipeline for as long as dmem_stall is high;
// mem_read/mem_write stay asserted with stable fields until the one-cycle mem_resp pulse completes them.
interface dmem_port_adapter_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err;

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  mem_rdata, mem_resp,
    output dmem_rdata, dmem_stall, mem_read, mem_write, mem_address, mem_wdata,
    output mem_byte_enable, err
  );

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output mem_rdata, mem_resp,
    input  dmem_rdata, dmem_stall, mem_read, mem_write, mem_address, mem_wdata,
    input  mem_byte_enable, err
  );
endinterface

// File: rtl/dmem_port_adapter.sv
// Turns single-cycle pipeline loads/stores into handshaked memory accesses, stalling the
// pipeline until each completes; a watchdog aborts accesses that never get a response.
module dmem_port_adapter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_adapter_if.slave  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic             rd_q;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             req;

  assign req = bus.dmem_read | bus.dmem_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A conflicting read+write is treated as a store and flagged.
            rd_q    <= bus.dmem_read & ~bus.dmem_write;
            wr_q    <= bus.dmem_write;
            addr_q  <= {bus.dmem_address[31:2], 2'b00};
            wdata_q <= bus.dmem_wdata;
            be_q    <= bus.dmem_byte_enable;
            cnt     <= '0;
            if (bus.dmem_read && bus.dmem_write) err_q <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            if (rd_q) rdata_q <= bus.mem_rdata;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt   <= '0;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          // The request still visible here belongs to the finished instruction.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are the latched flags, which are only set while BUSY.
  assign bus.mem_read        = rd_q;
  assign bus.mem_write       = wr_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.dmem_rdata      = rdata_q;
  assign bus.err             = err_q;
  assign bus.dmem_stall      = ((state == IDLE) && req) || (state == BUSY);
  assign state_dbg           = state;

endmodule
